// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - initiator/responder memory bus bundle
//
// Purpose: carries the controller's address/rden/wren/dataout bus to the
// memory responder and its read data back.
// Signals:
//   address  word address from initiator
//   rden     read enable
//   wren     write enable
//   data     write data (initiator dataout)
//   q        read data (initiator datain)
//   q_valid  one-cycle pulse marking each new q
// Modports: master (initiator side), slave (responder side).
interface mem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] address;
  logic              rden;
  logic              wren;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] q;
  logic              q_valid;

  modport master (
    output address, rden, wren, data,
    input  q, q_valid
  );

  modport slave (
    input  address, rden, wren, data,
    output q, q_valid
  );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - 32x16 synchronous memory responder with bus protocol monitors
//
// Purpose: answers the accumulator controller's memory bus with a synchronous
// RAM and a registered read pipeline of 1 or 2 edges, and latches sticky
// error flags when the initiator breaks the bus timing rules.
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous, active-low reset
//   bus             mem_responder_if.slave (address/rden/wren/data in, q/q_valid out)
//   err_setup       sticky: wren rose before the address was stable
//   err_addr_chg    sticky: address changed while wren was held
//   err_rden_short  sticky: rden pulse shorter than MIN_RDEN
//   err_conflict    sticky: rden and wren high at the same edge
//   wr_count        accepted writes, wrapping 8-bit count
//   rd_count        accepted reads, wrapping 8-bit count
module mem_responder #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 5,
  parameter int RD_LAT    = 2,   // 1 or 2; any value other than 1 builds the 2-edge pipe
  parameter int MIN_RDEN  = 4,
  parameter int MIN_SETUP = 1
) (
  input  logic             clk,
  input  logic             reset,
  mem_responder_if.slave   bus,
  output logic             err_setup,
  output logic             err_addr_chg,
  output logic             err_rden_short,
  output logic             err_conflict,
  output logic [7:0]       wr_count,
  output logic [7:0]       rd_count
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [2:0] AGE_MAX   = 3'd7;
  localparam logic [3:0] RUN_MAX   = 4'd15;
  localparam logic [2:0] SETUP_MIN = 3'(MIN_SETUP);
  localparam logic [3:0] RDEN_MIN  = 4'(MIN_RDEN);

  logic [DATA_W-1:0] mem [DEPTH];

  // A conflicting cycle still writes; only the read is dropped.
  logic do_read;
  logic conflict;
  assign do_read  = bus.rden & ~bus.wren;
  assign conflict = bus.rden & bus.wren;

  logic [DATA_W-1:0] rd_word;
  assign rd_word = mem[bus.address];

  // Memory array has no reset; writes are ignored while reset is held so the
  // contents survive a reset pulse untouched.
  always_ff @(posedge clk) begin
    if (reset && bus.wren) begin
      mem[bus.address] <= bus.data;
    end
  end

  // Protocol monitor state
  logic [ADDR_W-1:0] prev_addr;
  logic              have_prev;   // no previous address sample yet after reset
  logic              wren_prev;
  logic [2:0]        age;         // saturating count of samples with an unchanged address
  logic [3:0]        run;         // saturating length of the current rden run

  // Until the first post-reset sample there is nothing to compare against,
  // so the address counts as unchanged and stays stable.
  logic       addr_changed;
  logic [2:0] age_next;
  assign addr_changed = have_prev && (bus.address != prev_addr);
  assign age_next     = addr_changed     ? 3'd0 :
                        (age == AGE_MAX) ? AGE_MAX : age + 3'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_addr      <= '0;
      have_prev      <= 1'b0;
      wren_prev      <= 1'b0;
      age            <= AGE_MAX;
      run            <= '0;
      err_setup      <= 1'b0;
      err_addr_chg   <= 1'b0;
      err_rden_short <= 1'b0;
      err_conflict   <= 1'b0;
      wr_count       <= '0;
      rd_count       <= '0;
    end else begin
      prev_addr <= bus.address;
      have_prev <= 1'b1;
      wren_prev <= bus.wren;
      age       <= age_next;

      // Setup is judged on the age including this sample, so an address that
      // changes on the same edge wren rises has age 0.
      if (bus.wren && !wren_prev && (age_next < SETUP_MIN)) begin
        err_setup <= 1'b1;
      end
      if (bus.wren && wren_prev && addr_changed) begin
        err_addr_chg <= 1'b1;
      end

      if (bus.rden) begin
        if (run != RUN_MAX) begin
          run <= run + 4'd1;
        end
      end else begin
        if ((run != 4'd0) && (run < RDEN_MIN)) begin
          err_rden_short <= 1'b1;
        end
        run <= '0;
      end

      if (conflict) begin
        err_conflict <= 1'b1;
      end
      if (bus.wren) begin
        wr_count <= wr_count + 8'd1;
      end
      if (do_read) begin
        rd_count <= rd_count + 8'd1;
      end
    end
  end

  // Read pipeline: q only moves when a read completes, otherwise it holds.
  generate
    if (RD_LAT == 1) begin : g_lat1
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          bus.q       <= '0;
          bus.q_valid <= 1'b0;
        end else begin
          bus.q_valid <= do_read;
          if (do_read) begin
            bus.q <= rd_word;
          end
        end
      end
    end else begin : g_lat2
      logic [DATA_W-1:0] s1_data;
      logic              s1_valid;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          s1_data     <= '0;
          s1_valid    <= 1'b0;
          bus.q       <= '0;
          bus.q_valid <= 1'b0;
        end else begin
          s1_valid <= do_read;
          if (do_read) begin
            s1_data <= rd_word;
          end
          bus.q_valid <= s1_valid;
          if (s1_valid) begin
            bus.q <= s1_data;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder
module tb_mem_responder;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 5;
  localparam int RD_LAT    = 2;
  localparam int MIN_RDEN  = 4;
  localparam int MIN_SETUP = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  logic       err_setup, err_addr_chg, err_rden_short, err_conflict;
  logic [7:0] wr_count, rd_count;

  mem_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT),
    .MIN_RDEN(MIN_RDEN), .MIN_SETUP(MIN_SETUP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .err_setup(err_setup),
    .err_addr_chg(err_addr_chg),
    .err_rden_short(err_rden_short),
    .err_conflict(err_conflict),
    .wr_count(wr_count),
    .rd_count(rd_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference model
  typedef struct {
    int data;
    int due;
  } exp_t;

  logic [15:0] m_mem [32];
  int   m_wr, m_rd;
  bit   m_es, m_ea, m_er, m_ec;
  int   m_age, m_run, m_prev_a;
  bit   m_have_prev, m_wprev;
  int   cyc = 0;
  int   last_q;
  exp_t exp_q[$];
  int   rx_log[$];

  task automatic model_reset();
    exp_q.delete();
    last_q      = 0;
    m_wr        = 0;
    m_rd        = 0;
    m_es        = 0;
    m_ea        = 0;
    m_er        = 0;
    m_ec        = 0;
    m_age       = 7;
    m_run       = 0;
    m_prev_a    = 0;
    m_have_prev = 0;
    m_wprev     = 0;
  endtask

  task automatic model_edge(input int a, input bit r, input bit w, input int d);
    bit chg;
    chg = m_have_prev && (a != m_prev_a);
    // Cycles the address has been unchanged; only "< MIN_SETUP" matters.
    m_age = chg ? 0 : m_age + 1;
    if (w && !m_wprev && m_age < MIN_SETUP) m_es = 1;
    if (w && m_wprev && chg) m_ea = 1;
    if (r) m_run++;
    else begin
      if (m_run > 0 && m_run < MIN_RDEN) m_er = 1;
      m_run = 0;
    end
    if (r && w) m_ec = 1;
    if (r && !w) begin
      exp_q.push_back('{data: int'(m_mem[a]), due: cyc + RD_LAT - 1});
      m_rd = (m_rd + 1) % 256;
    end
    if (w) begin
      m_mem[a] = d[15:0];
      m_wr = (m_wr + 1) % 256;
    end
    m_prev_a    = a;
    m_have_prev = 1;
    m_wprev     = w;
  endtask

  // Drive one cycle of bus inputs, let the edge happen, then move off it.
  task automatic step(input int a, input bit r, input bit w, input int d);
    bus.address = a[4:0];
    bus.rden    = r;
    bus.wren    = w;
    bus.data    = d[15:0];
    @(posedge clk);
    cyc++;
    if (reset) model_edge(a, r, w, d);
    #1;
  endtask

  task automatic idle(input int a, input int n);
    for (int i = 0; i < n; i++) step(a, 0, 0, 0);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_err_setup"},      int'(err_setup),      int'(m_es));
    check({tag, "_err_addr_chg"},   int'(err_addr_chg),   int'(m_ea));
    check({tag, "_err_rden_short"}, int'(err_rden_short), int'(m_er));
    check({tag, "_err_conflict"},   int'(err_conflict),   int'(m_ec));
    check({tag, "_wr_count"},       int'(wr_count),       m_wr);
    check({tag, "_rd_count"},       int'(rd_count),       m_rd);
  endtask

  // Monitor: pops the scoreboard whenever q_valid is presented.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      check("rst_q_valid", int'(bus.q_valid), 0);
      check("rst_q", int'(bus.q), 0);
    end else if (bus.q_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_q_valid", int'(bus.q_valid), 0);
      end else begin
        e = exp_q.pop_front();
        check("rd_data", int'(bus.q), e.data);
        check("rd_latency", cyc, e.due);
        last_q = e.data;
        rx_log.push_back(int'(bus.q));
      end
    end else begin
      check("q_hold", int'(bus.q), last_q);
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        check("missing_q_valid", int'(bus.q_valid), 1);
        e = exp_q.pop_front();
      end
    end
  end

  initial begin
    int sum;
    int v;
    int rd_before;
    int a;
    bit r, w;

    // Reset / idle
    reset       = 1'b0;
    bus.address = '0;
    bus.rden    = 1'b0;
    bus.wren    = 1'b0;
    bus.data    = '0;
    model_reset();
    idle(0, 3);
    reset = 1'b1;
    #1;
    check("init_q",       int'(bus.q), 0);
    check("init_q_valid", int'(bus.q_valid), 0);
    check("init_errs",    int'({err_setup, err_addr_chg, err_rden_short, err_conflict}), 0);
    check("init_wr",      int'(wr_count), 0);
    check("init_rd",      int'(rd_count), 0);

    // Single write then a 4-cycle read burst
    step(3, 0, 0, 0);
    step(3, 0, 1, 16'h1234);
    rx_log.delete();
    for (int i = 0; i < 4; i++) step(3, 1, 0, 0);
    idle(3, 4);
    check("p2_wr_count", int'(wr_count), 1);
    check("p2_rd_count", int'(rd_count), 4);
    check("p2_rx_n", rx_log.size(), 4);
    check_state("p2");

    // Fill 0..31 with 2*i+1, read everything back in one burst
    for (int i = 0; i < 32; i++) begin
      step(i, 0, 0, 0);
      step(i, 0, 1, 2 * i + 1);
    end
    rx_log.delete();
    for (int i = 0; i < 32; i++) step(i, 1, 0, 0);
    idle(31, 4);
    check("fill_rx_n", rx_log.size(), 32);
    sum = 0;
    for (int i = 0; i < 7 && i < rx_log.size(); i++) sum += rx_log[i];
    check("fill_sum_0_6", sum, 49);
    check_state("fill");

    // Setup violation, then address change with wren held
    idle(5, 2);
    step(6, 0, 1, 16'hA5A5);
    check("setup_err_setup", int'(err_setup), 1);
    step(7, 0, 1, 16'h5A5A);
    step(7, 0, 0, 0);
    check("setup_err_addr_chg", int'(err_addr_chg), 1);
    rx_log.delete();
    for (int i = 0; i < 4; i++) step(6, 1, 0, 0);
    idle(6, 4);
    v = (rx_log.size() > 0) ? rx_log[0] : -1;
    check("setup_mem6", v, 16'hA5A5);
    check_state("setup");

    // Short rden pulse, then a read/write conflict
    step(9, 1, 0, 0);
    step(9, 1, 0, 0);
    step(9, 0, 0, 0);
    check("short_err_rden_short", int'(err_rden_short), 1);
    rd_before = m_rd;
    step(9, 1, 1, 16'hBEEF);
    step(9, 0, 0, 0);
    check("conf_err_conflict", int'(err_conflict), 1);
    check("conf_rd_unchanged", int'(rd_count), rd_before);
    rx_log.delete();
    for (int i = 0; i < 4; i++) step(9, 1, 0, 0);
    idle(9, 4);
    v = (rx_log.size() > 0) ? rx_log[0] : -1;
    check("conf_mem9", v, 16'hBEEF);
    check_state("conf");

    // Reset one cycle after rden rises: in-flight read must vanish
    step(2, 1, 0, 0);
    reset = 1'b0;
    model_reset();
    #1;
    check("midrst_q",       int'(bus.q), 0);
    check("midrst_q_valid", int'(bus.q_valid), 0);
    check("midrst_errs",    int'({err_setup, err_addr_chg, err_rden_short, err_conflict}), 0);
    check("midrst_rd",      int'(rd_count), 0);
    idle(2, 3);
    reset = 1'b1;
    idle(2, 4);
    for (int i = 0; i < 4; i++) step(9, 1, 0, 0);
    idle(9, 1);
    for (int i = 0; i < 4; i++) step(6, 1, 0, 0);
    idle(6, 4);
    check_state("midrst");

    // Randomized traffic against the model, starting from clean flags
    reset = 1'b0;
    model_reset();
    idle(0, 2);
    reset = 1'b1;
    a = 0;
    r = 0;
    w = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 31);
      if ($urandom_range(0, 2) == 0) r = ~r;
      if ($urandom_range(0, 3) == 0) w = ~w;
      step(a, r, w, int'($urandom_range(0, 65535)));
      if (i % 16 == 15) check_state("rand");
    end
    idle(a, 5);
    check_state("end");
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
